// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS ALU: operation codes, the per-bit slice
// selector and a helper that tells defined operations apart from the rest.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_AND = 4'b0000;
    localparam alu_op_t ALU_OR  = 4'b0001;
    localparam alu_op_t ALU_ADD = 4'b0010;
    localparam alu_op_t ALU_SUB = 4'b0110;
    localparam alu_op_t ALU_SLT = 4'b0111;
    localparam alu_op_t ALU_NOR = 4'b1100;

    // Low two ALUop bits pick the slice output; inversion and carry-in come from the upper bits.
    typedef enum logic [1:0] {
        SLICE_AND  = 2'b00,
        SLICE_OR   = 2'b01,
        SLICE_ADD  = 2'b10,
        SLICE_LESS = 2'b11
    } slice_op_t;

    function automatic logic op_is_defined(input alu_op_t op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arithmetic_logic_unit_if.sv
// Operand/result bundle between the ALU control path and the ALU itself.
interface arithmetic_logic_unit_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_t          ALUop;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output a, b, ALUop,
        input  result, zero, overflow
    );

    modport slave (
        input  a, b, ALUop,
        output result, zero, overflow
    );

endinterface

// File: rtl/alu_bit_slice.sv
// One bit of the ripple ALU: optional operand inversion, full adder and a
// four-way output select (AND, OR, SUM, LESS).
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      ainvert,
    input  logic      binvert,
    input  logic      carry_in,
    input  logic      less,
    input  slice_op_t op,
    output logic      result,
    output logic      carry_out
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a       = a ^ ainvert;
    assign w_b       = b ^ binvert;
    assign w_sum     = w_a ^ w_b ^ carry_in;
    assign carry_out = (w_a & w_b) | (carry_in & (w_a ^ w_b));

    always_comb begin
        // NOTE: a default before the case keeps this purely combinational (no latch).
        result = 1'b0;
        case (op)
            SLICE_AND:  result = w_a & w_b;
            SLICE_OR:   result = w_a | w_b;
            SLICE_ADD:  result = w_sum;
            SLICE_LESS: result = less;
            default:    result = 1'b0;
        endcase
    end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// 32-bit MIPS ALU built from a ripple chain of bit slices; result, zero and
// overflow are registered one cycle after the operands are presented.
module arithmetic_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    arithmetic_logic_unit_if.slave  bus
);

    logic             w_ainvert;
    logic             w_binvert;
    slice_op_t        w_slice_op;
    logic [WIDTH-1:0] w_slice_result;
    logic             w_msb_sum;
    logic             w_ovf_internal;
    logic             w_less;
    logic             w_is_addsub;
    logic [WIDTH-1:0] w_next_result;
    logic             w_next_overflow;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;

    // SUB/SLT invert b and inject the +1 through the carry-in; NOR inverts a as well.
    assign w_ainvert  = bus.ALUop[3];
    assign w_binvert  = bus.ALUop[2];
    assign w_slice_op = slice_op_t'(bus.ALUop[1:0]);

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic w_cin;
        logic w_cout;
        logic w_less_in;

        if (i == 0) begin : g_lsb
            assign w_cin     = w_binvert;
            assign w_less_in = w_less;
        end else begin : g_chain
            assign w_cin     = g_slice[i-1].w_cout;
            assign w_less_in = 1'b0;
        end

        alu_bit_slice u_slice (
            .a         (bus.a[i]),
            .b         (bus.b[i]),
            .ainvert   (w_ainvert),
            .binvert   (w_binvert),
            .carry_in  (w_cin),
            .less      (w_less_in),
            .op        (w_slice_op),
            .result    (w_slice_result[i]),
            .carry_out (w_cout)
        );
    end

    // The MSB sum is rebuilt here because the top slice outputs LESS, not SUM, during SLT.
    assign w_msb_sum      = (bus.a[WIDTH-1] ^ w_ainvert) ^ (bus.b[WIDTH-1] ^ w_binvert)
                            ^ g_slice[WIDTH-1].w_cin;
    assign w_ovf_internal = g_slice[WIDTH-1].w_cin ^ g_slice[WIDTH-1].w_cout;
    assign w_less         = w_msb_sum ^ w_ovf_internal;

    assign w_is_addsub     = (bus.ALUop == ALU_ADD) || (bus.ALUop == ALU_SUB);
    assign w_next_result   = op_is_defined(bus.ALUop) ? w_slice_result : '0;
    assign w_next_overflow = w_is_addsub & w_ovf_internal;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (rst) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_result   <= w_next_result;
            r_zero     <= (w_next_result == '0);
            r_overflow <= w_next_overflow;
        end
    end

    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Scoreboard bench for arithmetic_logic_unit: directed corner vectors, then
// random back-to-back traffic with a mid-stream reset.
module tb_arithmetic_logic_unit;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        overflow;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    arithmetic_logic_unit_if #(.WIDTH(32)) bus ();

    arithmetic_logic_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference model: plain signed/unsigned arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op, input string name);
        exp_t   e;
        longint sa;
        longint sb;
        longint s;
        sa         = longint'($signed(a));
        sb         = longint'($signed(b));
        e.result   = 32'h0;
        e.overflow = 1'b0;
        e.name     = name;
        case (op)
            4'b0000: e.result = a & b;
            4'b0001: e.result = a | b;
            4'b0010: begin
                e.result   = a + b;
                s          = sa + sb;
                e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                e.result   = a - b;
                s          = sa - sb;
                e.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: e.result = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: e.result = ~(a | b);
            default: e.result = 32'h0;
        endcase
        e.zero = (e.result == 32'h0);
        return e;
    endfunction

    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input string name);
        exp_t e;
        @(negedge clk);
        rst       = r;
        bus.a     = a;
        bus.b     = b;
        bus.ALUop = op;
        if (r) begin
            e.result   = 32'h0;
            e.zero     = 1'b1;
            e.overflow = 1'b0;
            e.name     = name;
        end else begin
            e = model(a, b, op, name);
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic logic [3:0] pick_op();
        logic [3:0] ops [6];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
        ops[3] = 4'b0110; ops[4] = 4'b0111; ops[5] = 4'b1100;
        if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
        return ops[$urandom_range(0, 5)];
    endfunction

    // Monitor: one registered output per edge, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".result"},   bus.result,          e.result);
                check({e.name, ".zero"},     {31'b0, bus.zero},     {31'b0, e.zero});
                check({e.name, ".overflow"}, {31'b0, bus.overflow}, {31'b0, e.overflow});
            end
        end
    end

    initial begin
        int waited;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
        bus.ALUop = '0;

        apply(1'b1, 32'd77, 32'd33, 4'b0000, "reset0");
        apply(1'b1, 32'd77, 32'd33, 4'b0000, "reset1");
        apply(1'b0, 32'd77, 32'd33, 4'b0000, "and_77_33");
        apply(1'b0, 32'd77, 32'd33, 4'b0001, "or_77_33");
        apply(1'b0, 32'd77, 32'd33, 4'b1100, "nor_77_33");
        apply(1'b0, 32'd77, 32'd33, 4'b0011, "undef_0011");
        apply(1'b0, 32'd77, 32'd33, 4'b0010, "add_77_33");
        apply(1'b0, 32'd77, 32'd33, 4'b0110, "sub_77_33");
        apply(1'b0, 32'd33, 32'd33, 4'b0110, "sub_33_33");
        apply(1'b0, 32'd77, 32'd33, 4'b0111, "slt_77_33");
        apply(1'b0, 32'd33, 32'd77, 4'b0111, "slt_33_77");
        apply(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0111, "slt_m1_1");
        apply(1'b0, 32'h8000_0000, 32'd1, 4'b0111, "slt_min_1");
        apply(1'b0, 32'h7FFF_FFFF, 32'd1, 4'b0010, "add_ovf");
        apply(1'b0, 32'h8000_0000, 32'd1, 4'b0110, "sub_ovf");
        apply(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0010, "add_wrap");
        apply(1'b0, 32'h7FFF_FFFF, 32'd1, 4'b0111, "slt_no_ovf_flag");

        for (int i = 0; i < 1000; i++) begin
            if (i == 500)
                apply(1'b1, pick_operand(), pick_operand(), pick_op(), "mid_reset");
            else
                apply(1'b0, pick_operand(), pick_operand(), pick_op(), $sformatf("rnd%0d", i));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
